fp16_div: RTL



---
 rtl/fp16_div_if.sv | 22 ++
 rtl/fp16_div.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fp16_div_if.sv
// Operand/result handshake bundle for the binary16 divider.
// master = producer/consumer side, slave = the divider.
interface fp16_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, dz
  );
endinterface

// File: rtl/fp16_div.sv
// Sequential binary16 divider: special-case bypass, 13-step restoring mantissa
// division, round-to-nearest-even, one operation in flight.
module fp16_div (
  input  logic       clk,
  input  logic       rst_n,
  fp16_div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
  state_t state_reg, state_next;

  logic [12:0] rem_reg;
  logic [10:0] mb_reg;
  logic [12:0] q_reg;
  logic [3:0]  count_reg;
  logic        sign_reg;
  logic [6:0]  exp_reg;
  logic [15:0] result_reg;
  logic        dz_reg;
  logic        out_valid_reg;

  // Operand classification; subnormals have exponent 0 and count as zero.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
  assign a_zero  = (bus.a[14:10] == 5'd0);
  assign b_zero  = (bus.b[14:10] == 5'd0);
  assign a_inf   = (bus.a[14:10] == 5'd31) && (bus.a[9:0] == 10'd0);
  assign b_inf   = (bus.b[14:10] == 5'd31) && (bus.b[9:0] == 10'd0);
  assign a_nan   = (bus.a[14:10] == 5'd31) && (bus.a[9:0] != 10'd0);
  assign b_nan   = (bus.b[14:10] == 5'd31) && (bus.b[9:0] != 10'd0);
  assign sign_in = bus.a[15] ^ bus.b[15];

  logic        special;
  logic [15:0] special_result;
  logic        special_dz;

  always_comb begin
    special        = 1'b1;
    special_dz     = 1'b0;
    special_result = 16'h7E00;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_result = 16'h7E00;
    end else if (a_inf) begin
      special_result = {sign_in, 5'h1F, 10'd0};
    end else if (b_zero) begin
      special_result = {sign_in, 5'h1F, 10'd0};
      special_dz     = 1'b1;
    end else if (a_zero || b_inf) begin
      special_result = {sign_in, 15'd0};
    end else begin
      special        = 1'b0;
    end
  end

  // One restoring step: the partial remainder always stays below 2*mb.
  logic        q_bit;
  logic [12:0] rem_sub;
  logic [12:0] rem_shift;
  assign q_bit     = (rem_reg >= {2'b00, mb_reg});
  assign rem_sub   = q_bit ? (rem_reg - {2'b00, mb_reg}) : rem_reg;
  assign rem_shift = {rem_sub[11:0], 1'b0};

  // Rounding: a carry out of the fraction ripples straight into the exponent.
  logic        dec;
  logic [9:0]  frac_raw;
  logic        guard, sticky, round_up;
  logic [6:0]  e_norm;
  logic [16:0] packed_rnd;
  logic [6:0]  e_fin;
  logic [15:0] norm_result;

  always_comb begin
    dec         = ~q_reg[12];
    frac_raw    = q_reg[12] ? q_reg[11:2] : q_reg[10:1];
    guard       = q_reg[12] ? q_reg[1] : q_reg[0];
    sticky      = (q_reg[12] & q_reg[0]) | (rem_reg != 13'd0);
    round_up    = guard & (sticky | frac_raw[0]);
    e_norm      = exp_reg - {6'd0, dec};
    packed_rnd  = {e_norm, frac_raw} + {16'd0, round_up};
    e_fin       = packed_rnd[16:10];
    norm_result = {sign_reg, e_fin[4:0], packed_rnd[9:0]};
    if (!e_fin[6] && (e_fin >= 7'd31)) begin
      norm_result = {sign_reg, 5'h1F, 10'd0};
    end else if (e_fin[6] || (e_fin == 7'd0)) begin
      norm_result = {sign_reg, 15'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = special ? DONE : DIVIDE;
      DIVIDE:  if (count_reg == 4'd12) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg       <= 13'd0;
      mb_reg        <= 11'd0;
      q_reg         <= 13'd0;
      count_reg     <= 4'd0;
      sign_reg      <= 1'b0;
      exp_reg       <= 7'd0;
      result_reg    <= 16'h0000;
      dz_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sign_reg <= sign_in;
            if (special) begin
              result_reg    <= special_result;
              dz_reg        <= special_dz;
              out_valid_reg <= 1'b1;
            end else begin
              rem_reg   <= {2'b01, bus.a[9:0]};
              mb_reg    <= {1'b1, bus.b[9:0]};
              q_reg     <= 13'd0;
              count_reg <= 4'd0;
              exp_reg   <= {2'b00, bus.a[14:10]} - {2'b00, bus.b[14:10]} + 7'd15;
            end
          end
        end
        DIVIDE: begin
          q_reg     <= {q_reg[11:0], q_bit};
          rem_reg   <= rem_shift;
          count_reg <= count_reg + 4'd1;
        end
        ROUND: begin
          result_reg    <= norm_result;
          dz_reg        <= 1'b0;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            dz_reg        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.dz        = dz_reg;
endmodule
